// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with a valid/ready stream interface and a global stall.
// Define BSH_FLAGS_EN to add the out_zero/out_carry result flags and their pipeline registers.
module barrel_shifter_pipe #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   select_line,
  input  logic             left_rot,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BSH_FLAGS_EN
 ,output logic             out_zero,
  output logic             out_carry
`endif
);

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_ASR = 2'b10;

  // Stage 0 captures the raw operand; stage k+1 applies the 2^k step of stage k.
  logic [WIDTH-1:0] data_q [SHW+1];
  logic [SHW:0]     valid_q;
  logic [SHW-1:0]   amt_q  [SHW];
  logic [1:0]       mode_q [SHW];
  logic [SHW-1:0]   left_q;
  logic [SHW-1:0]   sign_q;
  logic             advance;

  assign advance   = ~valid_q[SHW] | out_ready;
  assign in_ready  = advance;
  assign out       = data_q[SHW];
  assign out_valid = valid_q[SHW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q[0] <= 1'b0;
      data_q[0]  <= '0;
      amt_q[0]   <= '0;
      mode_q[0]  <= '0;
      left_q[0]  <= 1'b0;
      sign_q[0]  <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in;
      amt_q[0]   <= select_line;
      mode_q[0]  <= mode;
      left_q[0]  <= left_rot;
      sign_q[0]  <= in[WIDTH-1];
    end
  end

`ifdef BSH_FLAGS_EN
  // Last bit shifted out, taken from the untouched operand; 0 - amt wraps to WIDTH - amt.
  logic [SHW-1:0] carry_idx;
  logic           carry_d;
  logic [SHW-1:0] carry_q;
  logic           zero_q;

  always_comb begin
    carry_idx = left_q[0] ? (SHW'(0) - amt_q[0]) : (amt_q[0] - SHW'(1));
    carry_d   = (amt_q[0] != '0) & data_q[0][carry_idx];
  end

  assign out_zero  = zero_q;
  assign out_carry = carry_q[SHW-1];
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned S = 2 ** k;
    logic [WIDTH-1:0] sh;

    // Arithmetic fill uses the original sign, so stacking steps stays exact.
    always_comb begin
      sh = data_q[k];
      if (amt_q[k][k]) begin
        if (mode_q[k] == MODE_ROT) begin
          sh = left_q[k] ? ((data_q[k] << S) | (data_q[k] >> (WIDTH - S)))
                         : ((data_q[k] >> S) | (data_q[k] << (WIDTH - S)));
        end else if (left_q[k]) begin
          sh = data_q[k] << S;
        end else if (mode_q[k] == MODE_ASR) begin
          sh = (data_q[k] >> S) | ({WIDTH{sign_q[k]}} << (WIDTH - S));
        end else begin
          sh = data_q[k] >> S;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k+1] <= 1'b0;
        data_q[k+1]  <= '0;
      end else if (advance) begin
        valid_q[k+1] <= valid_q[k];
        data_q[k+1]  <= sh;
      end
    end

    if (k + 1 < SHW) begin : g_ctl
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q[k+1]  <= '0;
          mode_q[k+1] <= '0;
          left_q[k+1] <= 1'b0;
          sign_q[k+1] <= 1'b0;
        end else if (advance) begin
          amt_q[k+1]  <= amt_q[k];
          mode_q[k+1] <= mode_q[k];
          left_q[k+1] <= left_q[k];
          sign_q[k+1] <= sign_q[k];
        end
      end
    end

`ifdef BSH_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q[k] <= 1'b0;
      end else if (advance) begin
        carry_q[k] <= (k == 0) ? carry_d : carry_q[(k == 0) ? 0 : k - 1];
      end
    end

    if (k == SHW - 1) begin : g_zero
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
        end else if (advance) begin
          zero_q <= (sh == '0);
        end
      end
    end
`endif
  end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter/rotator with a valid/ready stream interface. Generalises the 8-bit combinational rotator to any power-of-two width, adds logical and arithmetic shift modes, and registers one log2 shift stage per cycle so it closes timing at wide widths. It sits in the datapath between an operand source and any consumer that can apply backpressure.

## Interface
- `WIDTH`, 8, data width; power of two, ≥ 2.
- `SHW`, `$clog2(WIDTH)`, shift-amount width and pipeline depth. Derived; must not be overridden.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  WIDTH  operand.
- `select_line`  input  SHW  shift/rotate amount, 0..WIDTH-1.
- `left_rot`  input  1  direction: 1 = left, 0 = right.
- `mode`  input  2  00 rotate, 01 logical shift, 10 arithmetic shift, 11 reserved (behaves as 01).
- `in_valid`  input  1  operand valid.
- `in_ready`  output  1  block accepts an operand this cycle.
- `out`  output  WIDTH  result.
- `out_valid`  output  1  `out` valid.
- `out_ready`  input  1  consumer accepts the result.
- `out_zero`, `out_carry`  output  1 each  flags; present only with `BSH_FLAGS_EN`.

## Operation
- Transfer on input when `in_valid & in_ready`; on output when `out_valid & out_ready`.
- Pipeline of SHW register stages; stage k applies a shift of 2^k when bit k of the amount is set. Each stage register holds data, remaining amount bits, `mode`, `left_rot`, sign bit of the original operand, valid.
- Rotate: bits leaving one end re-enter the other (right rotate: out[j] = in[(j+amt)%WIDTH]).
- Logical: vacated positions filled with 0.
- Arithmetic right: vacated MSBs filled with the original in[WIDTH-1]. Arithmetic left identical to logical left.
- Amount 0: `out` = `in` for every mode.
- Global stall: `advance = ~out_valid | out_ready`; `in_ready = advance` (combinational). When `advance` = 0 every stage holds, including valid bits. When `advance` = 1 every stage loads from the previous one; stage 0 valid loads `in_valid`.
- Bubbles travel as invalid stages and are not compressed.
- `in_valid` without `in_ready` drops nothing: the operand is simply not taken; source holds it.
- Simultaneous output handshake and input acceptance in one cycle is supported; full throughput is one result per cycle.
- Reserved mode 11 is not flagged; treated exactly as 01.

## Timing
- Latency: operand accepted at edge N appears with `out_valid` = 1 after edge N+SHW (3 cycles for WIDTH = 8), given no stall.
- Stall for S cycles adds S cycles to latency of every in-flight operand; order preserved.
- Reset (asynchronous, any time, including mid-stream): all stage valids 0, all data/flag registers 0; `out` = 0, `out_valid` = 0, `in_ready` = 1 after reset. In-flight operands are discarded.
- First accept possible on the first rising edge with `rst_n` = 1.
- No combinational path from `in`/`in_valid` to any output; `out_ready` → `in_ready` is the only combinational path.

## Configuration
- `BSH_FLAGS_EN` defined: `out_zero` and `out_carry` ports and their pipeline registers exist. `out_zero` = (result == 0). `out_carry` = last bit shifted out: left ops in[WIDTH-amt], right ops in[amt-1]; 0 when amt = 0; same definition for rotates. Flags valid with `out_valid`, reset to 0.
- Not defined: ports and registers absent; data behaviour otherwise identical.

## Test plan
- WIDTH=8, in=0xB1, mode 00, left_rot 0, amt 3 → out=0x36 after 3 cycles; carry 0 (in[2]).
- in=0xB1, mode 00, left_rot 1, amt 3 → out=0x8D; carry 1 (in[5]); mode 01 same → out=0x88.
- in=0xB1, mode 10, right, amt 2 → out=0xEC; mode 01 right amt 4 → out=0x0B, carry 0; mode 01 left amt 4 → out=0x10.
- Back-to-back stream of 16 random operands with `out_ready` toggling 50%: results match a reference model in order, none lost or duplicated, `in_ready` low exactly when `out_valid & ~out_ready`.
- Assert `rst_n` = 0 with 3 operands in flight → `out_valid`, `out` go 0 immediately; after release no stale result emerges.
- amt 0 in all four modes, in=0x5A → out=0x5A, zero 0, carry 0; in=0x80, mode 01 left amt 1 → out=0x00, zero 1, carry 1.
